histogram_decompressor: RTL and testbench

//  Inverse of the 4-bin pair-histogram compressor: accepts the four counts (00/01/10/11) of a

---
 rtl/histogram_pkg.sv | 32 +++
 rtl/histdec_bin_select.sv | 56 +++++
 rtl/histogram_decompressor.sv | 127 ++++++++++++
 tb/tb_histogram_decompressor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// Shared definitions for the pair-histogram link (compressor and decompressor).
package histogram_pkg;

    localparam int unsigned NUM_BINS  = 4;
    localparam int unsigned BIN_IDX_W = 2;

    localparam logic [1:0] BIN_00 = 2'b00;
    localparam logic [1:0] BIN_01 = 2'b01;
    localparam logic [1:0] BIN_10 = 2'b10;
    localparam logic [1:0] BIN_11 = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEmit = 2'd1,
        StDone = 2'd2
    } hist_state_e;

    // Pair code {a,b} carried by a bin index.
    function automatic logic [1:0] bin_code(input logic [BIN_IDX_W-1:0] idx);
        logic [1:0] code;
        code = BIN_00;
        unique case (idx)
            2'd0: code = BIN_00;
            2'd1: code = BIN_01;
            2'd2: code = BIN_10;
            2'd3: code = BIN_11;
            default: code = BIN_00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/histdec_bin_select.sv
// Combinational bin picker: returns the next bin with a nonzero remaining count.
// Grouped priority by default; round-robin after ptr when HISTDEC_INTERLEAVE_EN is defined.
module histdec_bin_select
    import histogram_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8
) (
    input  logic [NUM_BINS-1:0][COUNTER_WIDTH-1:0] counts,
    input  logic [BIN_IDX_W-1:0]                   ptr,
    output logic [BIN_IDX_W-1:0]                   next_bin,
    output logic                                   any_left
);

    logic [NUM_BINS-1:0] nonzero;

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            nonzero[i] = |counts[i];
        end
    end

    assign any_left = |nonzero;

`ifdef HISTDEC_INTERLEAVE_EN
    logic                 found;
    logic [BIN_IDX_W-1:0] idx;

    // Search strictly after ptr, wrapping; ptr itself is the last candidate.
    always_comb begin
        next_bin = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_BINS; k++) begin
            idx = ptr + BIN_IDX_W'(k);
            if (!found && nonzero[idx]) begin
                next_bin = idx;
                found    = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        next_bin = '0;
        for (int i = NUM_BINS - 1; i >= 0; i--) begin
            if (nonzero[i]) begin
                next_bin = BIN_IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/histogram_decompressor.sv
// Regenerates a pair stream from a 4-bin histogram with a valid/ready output handshake.
// Emission order is grouped by default; HISTDEC_INTERLEAVE_EN selects round-robin order.
module histogram_decompressor
    import histogram_pkg::*;
#(
    parameter int unsigned STREAM_LENGTH = 128,
    parameter int unsigned COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] count_00,
    input  logic [COUNTER_WIDTH-1:0] count_01,
    input  logic [COUNTER_WIDTH-1:0] count_10,
    input  logic [COUNTER_WIDTH-1:0] count_11,
    output logic                     load_ready,
    output logic                     stream_a,
    output logic                     stream_b,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     decomp_done,
    output logic                     err_sum
);

    localparam logic [COUNTER_WIDTH+1:0] SumTarget = (COUNTER_WIDTH + 2)'(STREAM_LENGTH);
    localparam logic [COUNTER_WIDTH-1:0] LastIdx   = COUNTER_WIDTH'(STREAM_LENGTH - 1);

    hist_state_e state_q, state_d;

    logic [NUM_BINS-1:0][COUNTER_WIDTH-1:0] rem_q, rem_d, rem_dec, in_counts, sel_counts;
    logic [BIN_IDX_W-1:0]                   cur_q, cur_d, sel_ptr, sel_bin;
    logic [COUNTER_WIDTH-1:0]               cnt_q, cnt_d;
    logic                                   err_q, err_d;
    logic [COUNTER_WIDTH+1:0]               sum;
    logic                                   sel_any;

    assign in_counts = {count_11, count_10, count_01, count_00};
    assign sum = {2'b00, count_00} + {2'b00, count_01} + {2'b00, count_10} + {2'b00, count_11};

    always_comb begin
        rem_dec         = rem_q;
        rem_dec[cur_q]  = rem_q[cur_q] - COUNTER_WIDTH'(1);
    end

    // In IDLE the picker sees the offered counts with ptr at the last bin, so the search
    // starts at 00 and yields the lowest nonzero bin in both builds.
    assign sel_counts = (state_q == StIdle) ? in_counts : rem_dec;
    assign sel_ptr    = (state_q == StIdle) ? BIN_11 : cur_q;

    histdec_bin_select #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_bin_select (
        .counts  (sel_counts),
        .ptr     (sel_ptr),
        .next_bin(sel_bin),
        .any_left(sel_any)
    );

    logic unused_any;
    assign unused_any = sel_any;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    if (sum == SumTarget) begin
                        err_d   = 1'b0;
                        rem_d   = in_counts;
                        cur_d   = sel_bin;
                        cnt_d   = '0;
                        state_d = StEmit;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (ready_in) begin
                    rem_d = rem_dec;
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cur_d = sel_bin;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    logic [1:0] code;
    assign code        = bin_code(cur_q);
    assign valid_out   = (state_q == StEmit);
    assign stream_a    = valid_out & code[1];
    assign stream_b    = valid_out & code[0];
    assign load_ready  = (state_q == StIdle);
    assign decomp_done = (state_q == StDone);
    assign err_sum     = err_q;

endmodule

// File: tb/tb_histogram_decompressor.sv
// Self-checking bench for histogram_decompressor with a queue-based reference model.
module tb_histogram_decompressor;

    localparam int unsigned L  = 8;
    localparam int unsigned CW = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
    logic          ready_in = 1'b1;
    logic          load_ready, stream_a, stream_b, valid_out, decomp_done, err_sum;

    always #5 clk = ~clk;

    histogram_decompressor #(
        .STREAM_LENGTH(L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .count_00   (c00),
        .count_01   (c01),
        .count_10   (c10),
        .count_11   (c11),
        .load_ready (load_ready),
        .stream_a   (stream_a),
        .stream_b   (stream_b),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .decomp_done(decomp_done),
        .err_sum    (err_sum)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 emitting, 2 done; exp_q holds pairs still to emit.
    int         m_phase = 0;
    bit         m_err = 1'b0;
    logic [1:0] exp_q[$];

    function automatic void build(input int a, input int b, input int c, input int d);
        int rem[4];
        int left;
        rem[0] = a; rem[1] = b; rem[2] = c; rem[3] = d;
        left = a + b + c + d;
`ifdef HISTDEC_INTERLEAVE_EN
        // Each round emits one pair from every bin that still has pairs left.
        while (left > 0) begin
            for (int k = 0; k < 4; k++) begin
                if (rem[k] > 0) begin
                    exp_q.push_back(2'(k));
                    rem[k]--;
                    left--;
                end
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < rem[k]; n++) exp_q.push_back(2'(k));
        end
`endif
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (load) begin
                    if (int'(c00) + int'(c01) + int'(c10) + int'(c11) != L) begin
                        m_err = 1'b1;
                    end else begin
                        m_err = 1'b0;
                        build(int'(c00), int'(c01), int'(c10), int'(c11));
                        m_phase = 1;
                    end
                end
                1: if (ready_in) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("load_ready", int'(load_ready), int'(m_phase == 0));
        chk("valid_out", int'(valid_out), int'(m_phase == 1));
        chk("decomp_done", int'(decomp_done), int'(m_phase == 2));
        chk("err_sum", int'(err_sum), int'(m_err));
        if (m_phase == 1 && exp_q.size() > 0) chk("pair", int'({stream_a, stream_b}), int'(exp_q[0]));
    end

    logic [1:0] obs_q[$];
    int         done_cnt = 0;
    bit         rdy_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst_n && valid_out && ready_in) obs_q.push_back({stream_a, stream_b});
        if (rst_n && decomp_done) done_cnt++;
    end

    initial forever begin
        @(negedge clk);
        ready_in = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic do_load(input int a, input int b, input int c, input int d);
        @(negedge clk);
        load = 1'b1;
        c00 = CW'(a); c01 = CW'(b); c10 = CW'(c); c11 = CW'(d);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (load_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_in_time"}, int'(n < 300), 1);
    endtask

    task automatic check_seq(input string name, input logic [15:0] seq);
        logic [15:0] s;
        s = seq;
        chk({name, "_len"}, obs_q.size(), 8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            chk($sformatf("%s_pair%0d", name, i), int'(obs_q[i]), int'(s[2*(7-i) +: 2]));
        end
    endtask

`ifdef HISTDEC_INTERLEAVE_EN
    localparam logic [15:0] Seq3221 = 16'b00_01_10_11_00_01_10_00;
    localparam logic [15:0] Seq2222 = 16'b00_01_10_11_00_01_10_11;
`else
    localparam logic [15:0] Seq3221 = 16'b00_00_00_01_01_10_10_11;
    localparam logic [15:0] Seq2222 = 16'b00_00_01_01_10_10_11_11;
`endif
    localparam logic [15:0] Seq0008 = 16'hffff;
    localparam logic [15:0] Seq1115 = 16'b00_01_10_11_11_11_11_11;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, b, c, d, n, d0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_load_ready", int'(load_ready), 1);
        chk("reset_valid_out", int'(valid_out), 0);
        chk("reset_err_sum", int'(err_sum), 0);
        chk("reset_done", int'(decomp_done), 0);

        // Case 1: grouped/interleaved order with ready held high.
        obs_q.delete(); d0 = done_cnt;
        do_load(3, 2, 2, 1);
        wait_idle("case1");
        check_seq("case1", Seq3221);
        chk("case1_done_pulses", done_cnt - d0, 1);

        // Case 2: single-bin histogram, valid one cycle after accept.
        obs_q.delete();
        do_load(0, 0, 0, 8);
        chk("case2_valid_after_accept", int'(valid_out), 1);
        wait_idle("case2");
        check_seq("case2", Seq0008);

        // Case 3: bad sum, then a good one clears the error.
        do_load(3, 3, 3, 0);
        chk("case3_err_set", int'(err_sum), 1);
        chk("case3_still_ready", int'(load_ready), 1);
        @(negedge clk);
        chk("case3_no_valid", int'(valid_out), 0);
        obs_q.delete();
        do_load(2, 2, 2, 2);
        chk("case3_err_cleared", int'(err_sum), 0);
        wait_idle("case3");
        check_seq("case3", Seq2222);

        // Case 4: random backpressure.
        rdy_rand = 1'b1;
        obs_q.delete();
        do_load(3, 2, 2, 1);
        wait_idle("case4");
        check_seq("case4", Seq3221);

        // Case 5: load during EMIT is ignored.
        rdy_rand = 1'b0;
        obs_q.delete();
        do_load(3, 2, 2, 1);
        @(negedge clk);
        load = 1'b1; c00 = '0; c01 = '0; c10 = '0; c11 = CW'(8);
        @(negedge clk);
        load = 1'b0;
        wait_idle("case5");
        check_seq("case5", Seq3221);
        chk("case5_err", int'(err_sum), 0);

        // Case 6: async reset mid-stream, then a fresh stream.
        obs_q.delete(); d0 = done_cnt;
        do_load(3, 2, 2, 1);
        n = 0;
        while (obs_q.size() < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("case6_reached_4", int'(obs_q.size() >= 4), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("case6_async_valid", int'(valid_out), 0);
        chk("case6_async_ready", int'(load_ready), 1);
        chk("case6_async_pair", int'({stream_a, stream_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("case6_no_done", done_cnt - d0, 0);
        obs_q.delete();
        do_load(1, 1, 1, 5);
        wait_idle("case6");
        check_seq("case6", Seq1115);

        // Random histograms, some with bad sums, under random backpressure.
        rdy_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            a = $urandom_range(0, L);
            b = $urandom_range(0, L - a);
            c = $urandom_range(0, L - a - b);
            d = L - a - b - c;
            if ($urandom_range(0, 4) == 0) d = d + 1 + $urandom_range(0, 3);
            obs_q.delete();
            do_load(a, b, c, d);
            wait_idle("random");
            if (a + b + c + d == L) chk("random_len", obs_q.size(), L);
            else chk("random_bad_len", obs_q.size(), 0);
        end
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
